// File: rtl/uart_rx.sv
// Serial receiver for 11-bit frames (start, 8 data MSB-first, parity, stop).
// Presents each byte with a one-cycle valid strobe plus parity/framing flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data,
  output logic [10:0] packet,
  output logic        valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] N_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] H_M1 = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [7:0]        data_q, data_d;
  logic [10:0]       packet_q, packet_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q;

  // State, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      packet_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      packet_q  <= packet_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Next-state and sampling logic; flags default low so they only appear with valid
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    packet_d = packet_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == H_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == N_M1) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx_s_q};
          if (idx_q == LAST_IDX) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == N_M1) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == N_M1) begin
          cnt_d    = '0;
          data_d   = shift_q;
          packet_d = {1'b0, shift_q, par_q, rx_s_q};
          perr_d   = par_q ^ (^shift_q) ^ ODD_PARITY;
          ferr_d   = ~rx_s_q;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data       = data_q;
  assign packet     = packet_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with N = 16.
module tb_uart_rx;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  data;
  logic [10:0] packet;
  logic        valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int unsigned flag_leak = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  d;
    logic [10:0] p;
    logic        pe;
    logic        fe;
  } rec_t;
  rec_t q[$];

  uart_rx #(.CLKS_PER_BIT(N), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .packet(packet),
    .valid(valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid cycle; flags outside valid are tallied as leaks
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      q.push_back('{cyc: cyc, d: data, p: packet, pe: parity_err, fe: frame_err});
    end else if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
      flag_leak++;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] fr;
    fr = {1'b0, d, par, stop};
    for (int i = 10; i >= 0; i--) begin
      rx = fr[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", data); end
    n_cmp++; if (packet !== 11'h000) begin n_bad++; $display("FAIL reset_packet got=%h exp=000", packet); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    int unsigned t0;
    q.delete();
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 1) begin
      n_bad++; $display("FAIL basic_count got=%0d exp=1", q.size());
    end else begin
      n_cmp++; if (q[0].cyc != t0 + 171) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", q[0].cyc - t0, 171); end
      n_cmp++; if (q[0].d !== 8'hA5) begin n_bad++; $display("FAIL basic_data got=%h exp=a5", q[0].d); end
      n_cmp++; if (q[0].p !== 11'h295) begin n_bad++; $display("FAIL basic_packet got=%h exp=295", q[0].p); end
      n_cmp++; if (q[0].pe !== 1'b0) begin n_bad++; $display("FAIL basic_perr got=%b exp=0", q[0].pe); end
      n_cmp++; if (q[0].fe !== 1'b0) begin n_bad++; $display("FAIL basic_ferr got=%b exp=0", q[0].fe); end
    end
    n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL basic_hold got=%h exp=a5", data); end
  endtask

  task automatic test_parity;
    q.delete();
    send_frame(8'h07, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 1) begin
      n_bad++; $display("FAIL parity_count got=%0d exp=1", q.size());
    end else begin
      n_cmp++; if (q[0].d !== 8'h07) begin n_bad++; $display("FAIL parity_data got=%h exp=07", q[0].d); end
      n_cmp++; if (q[0].p !== 11'h01D) begin n_bad++; $display("FAIL parity_packet got=%h exp=01d", q[0].p); end
      n_cmp++; if (q[0].pe !== 1'b1) begin n_bad++; $display("FAIL parity_perr got=%b exp=1", q[0].pe); end
      n_cmp++; if (q[0].fe !== 1'b0) begin n_bad++; $display("FAIL parity_ferr got=%b exp=0", q[0].fe); end
    end
  endtask

  task automatic test_frame_err;
    q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_low got=%b exp=0", busy); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 1) begin
      n_bad++; $display("FAIL frame_count got=%0d exp=1", q.size());
    end else begin
      n_cmp++; if (q[0].d !== 8'h3C) begin n_bad++; $display("FAIL frame_data got=%h exp=3c", q[0].d); end
      n_cmp++; if (q[0].p !== 11'h0F0) begin n_bad++; $display("FAIL frame_packet got=%h exp=0f0", q[0].p); end
      n_cmp++; if (q[0].pe !== 1'b0) begin n_bad++; $display("FAIL frame_perr got=%b exp=0", q[0].pe); end
      n_cmp++; if (q[0].fe !== 1'b1) begin n_bad++; $display("FAIL frame_ferr got=%b exp=1", q[0].fe); end
    end
  endtask

  task automatic test_glitch;
    q.delete();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_low got=%b exp=0", busy); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL glitch_count got=%0d exp=0", q.size()); end
    n_cmp++; if (data !== 8'h3C) begin n_bad++; $display("FAIL glitch_data got=%h exp=3c", data); end
    n_cmp++; if (packet !== 11'h0F0) begin n_bad++; $display("FAIL glitch_packet got=%h exp=0f0", packet); end
  endtask

  task automatic test_back_to_back;
    q.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 2) begin
      n_bad++; $display("FAIL b2b_count got=%0d exp=2", q.size());
    end else begin
      n_cmp++; if (q[1].cyc - q[0].cyc != 176) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=176", q[1].cyc - q[0].cyc); end
      n_cmp++; if (q[0].d !== 8'h55) begin n_bad++; $display("FAIL b2b_data0 got=%h exp=55", q[0].d); end
      n_cmp++; if (q[1].d !== 8'hAA) begin n_bad++; $display("FAIL b2b_data1 got=%h exp=aa", q[1].d); end
      n_cmp++; if ({q[0].pe, q[0].fe, q[1].pe, q[1].fe} !== 4'b0000) begin
        n_bad++; $display("FAIL b2b_flags got=%b%b%b%b exp=0000", q[0].pe, q[0].fe, q[1].pe, q[1].fe);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    q.delete();
    fr = {1'b0, 8'hF8, 1'b1, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      rx = fr[i];
      repeat (N) @(negedge clk);
    end
    rx = fr[5];
    repeat (N / 2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL mid_data got=%h exp=00", data); end
    n_cmp++; if (packet !== 11'h000) begin n_bad++; $display("FAIL mid_packet got=%h exp=000", packet); end
    rst = 1'b0;
    rx  = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL mid_no_valid got=%0d exp=0", q.size()); end
    send_frame(8'h81, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 1) begin
      n_bad++; $display("FAIL mid_next_count got=%0d exp=1", q.size());
    end else begin
      n_cmp++; if (q[0].d !== 8'h81) begin n_bad++; $display("FAIL mid_next_data got=%h exp=81", q[0].d); end
      n_cmp++; if (q[0].p !== 11'h205) begin n_bad++; $display("FAIL mid_next_packet got=%h exp=205", q[0].p); end
      n_cmp++; if ({q[0].pe, q[0].fe} !== 2'b00) begin n_bad++; $display("FAIL mid_next_flags got=%b%b exp=00", q[0].pe, q[0].fe); end
    end
  endtask

  task automatic test_flag_qualify;
    n_cmp++; if (flag_leak != 0) begin n_bad++; $display("FAIL flags_without_valid got=%0d exp=0", flag_leak); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_flag_qualify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the lab4 UART transmitter. Monitors a single serial line and recovers 11-bit frames: start bit, 8 data bits MSB-first, even-parity bit, stop bit. The first bit on the wire is frame bit 10, matching the transmitter's shift-out order. Sits between the board RX pin and downstream logic and presents each byte with a one-cycle valid strobe plus error flags.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit (N). Legal range 4..65535.
- ODD_PARITY, default 0: 0 = even parity expected, 1 = odd parity expected.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  last received data byte, MSB = first data bit on the wire.
- packet  output  11  last full frame as received: [10] start, [9:2] data, [1] parity, [0] stop.
- valid  output  1  one-cycle strobe; data, packet and error flags are updated in this cycle.
- parity_err  output  1  qualified by valid: received parity bit mismatches the computed parity.
- frame_err  output  1  qualified by valid: stop bit sampled 0.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchronizer (rx_s), reset to 1. A third flop holds rx_s from the previous cycle for edge detection.
- Let H = CLKS_PER_BIT/2 (integer division). A 16-bit cycle counter and a 4-bit bit index drive sampling.
- FSM states:
  - IDLE: wait for a falling edge on rx_s (previous 1, current 0). On the edge, clear the counter and go to START. A line held low never triggers.
  - START: sample rx_s when the counter reaches H−1.
    - Sampled 0: clear the counter and index, go to DATA.
    - Sampled 1: glitch; return to IDLE with no outputs.
  - DATA: sample every N cycles and shift into the data register MSB-first. After the 8th sample go to PARITY.
  - PARITY: sample once after N cycles, then go to STOP.
  - STOP: sample once after N cycles. Then:
    - Register data and packet.
    - Compute parity_err = parity_bit XOR (^data) XOR ODD_PARITY.
    - Compute frame_err = ~stop_bit.
    - Assert valid for exactly one cycle and return to IDLE.
- Error frames are still delivered: valid = 1 and data is updated.
- busy = (state != IDLE).

## Timing
- Reset values:
  - data = 0, packet = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - FSM in IDLE, sync flops = 1.
- Let T be the cycle in which rx_s first reads 0 after reading 1.
- Sample points:
  - Start bit at T+H.
  - Data bit k (k = 0..7) at T+H+(k+1)·N.
  - Parity at T+H+9N.
  - Stop at T+H+10N.
- valid, data, packet and the flags are visible in cycle T+H+10N+1. valid drops the following cycle.
- The pin-to-rx_s delay is 2 cycles.
- parity_err and frame_err are 0 in every cycle in which valid = 0.
- Back-to-back frames: IDLE is re-entered in the valid cycle, so a new start edge is detected from that cycle on. There is no minimum idle gap beyond the stop bit.
- rst asserted mid-frame: in the next cycle the FSM is in IDLE and all outputs hold their reset values. No valid is produced for the aborted frame.
- rst has priority over every other event in the same cycle.

## Test plan
- N=16, send 0xA5 with even parity 0 and stop 1 → single valid pulse at T+169. data=0xA5, packet=0x295, parity_err=0, frame_err=0.
- Send 0x07 with parity bit 0 (correct value is 1) → valid=1, data=0x07, parity_err=1, frame_err=0.
- Send 0x3C with stop bit 0, then hold rx low for 40 cycles → valid with frame_err=1. No second frame starts until rx goes high and then falls again.
- Low glitch of 4 cycles on idle rx → busy pulses high, then returns to IDLE. No valid; outputs unchanged.
- Two frames 0x55 then 0xAA, the second start bit immediately after the first stop bit → two valid pulses 176 cycles apart, with the correct data for each.
- Assert rst for 1 cycle during data bit 4 of a frame → busy=0 the next cycle, no valid for that frame. A subsequent clean 0x81 frame is received correctly.
